// File: rtl/ne_decoder_pkg.sv
// Shared state encoding and default sizing for the decode sequencer.
package ne_decoder_pkg;
    localparam int DEF_NB             = 16;
    localparam int DEF_ADDRESSWIDTH   = 5;
    localparam int DEF_ROWDEPTH       = 20;
    localparam int DEF_LAYERS         = 2;
    localparam int DEF_LAYERBITS      = 1;
    localparam int DEF_MAXITRS        = 2;
    localparam int DEF_ITRWIDTH       = 4;
    localparam int DEF_PIPESTAGES     = 15;
    localparam int DEF_PIPECOUNTWIDTH = 4;
    localparam int DEF_UNLOADCOUNT    = 17;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DECODE, S_DRAIN, S_CHECK, S_UNLOAD
    } seq_state_t;
endpackage

// File: rtl/ne_seq_counter.sv
// Loadable up-counter that wraps to zero after LAST and flags the terminal count.
module ne_seq_counter #(
    parameter int WIDTH = 5,
    parameter int LAST  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);
    assign tc = (count == WIDTH'(LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= tc ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/ne_decode_sequencer.sv
// Frame sequencer for a layered decoder: load, per-layer row sweep + drain, check, unload.
module ne_decode_sequencer
    import ne_decoder_pkg::*;
#(
    parameter int NB             = DEF_NB,
    parameter int ADDRESSWIDTH   = DEF_ADDRESSWIDTH,
    parameter int ROWDEPTH       = DEF_ROWDEPTH,
    parameter int LAYERS         = DEF_LAYERS,
    parameter int LAYERBITS      = DEF_LAYERBITS,
    parameter int MAXITRS        = DEF_MAXITRS,
    parameter int ITRWIDTH       = DEF_ITRWIDTH,
    parameter int PIPESTAGES     = DEF_PIPESTAGES,
    parameter int PIPECOUNTWIDTH = DEF_PIPECOUNTWIDTH,
    parameter int UNLOADCOUNT    = DEF_UNLOADCOUNT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    code_start,
    input  logic [ITRWIDTH-1:0]     iter_limit,
    input  logic                    syndrome_ok,
    input  logic                    unload_ready,
    output logic                    load_en,
    output logic [ADDRESSWIDTH-1:0] load_addr,
    output logic                    row_en,
    output logic [ADDRESSWIDTH-1:0] row_addr,
    output logic [LAYERBITS-1:0]    layer,
    output logic [ITRWIDTH-1:0]     itr_count,
    output logic                    decoder_ready,
    output logic                    unload_en,
    output logic [ADDRESSWIDTH-1:0] unload_addr,
    output logic                    busy,
    output logic                    early_term,
    output logic                    start_overflow
);
    seq_state_t                state;
    logic                      pending;
    logic [ITRWIDTH-1:0]       limit, lim_eff, itr_next;
    logic                      load_tc, row_tc, drain_tc, unload_tc;
    logic [PIPECOUNTWIDTH-1:0] drain_cnt;
    logic                      in_idle;
    logic                      drain_unused;

    assign in_idle      = (state == S_IDLE);
    assign unload_en    = (state == S_UNLOAD) && unload_ready;
    assign itr_next     = itr_count + 1'b1;
    // only the drain terminal flag steers the FSM
    assign drain_unused = ^drain_cnt;

    always_comb begin
        lim_eff = iter_limit;
        if (iter_limit == '0 || int'(iter_limit) > MAXITRS)
            lim_eff = ITRWIDTH'(MAXITRS);
    end

    ne_seq_counter #(.WIDTH(ADDRESSWIDTH), .LAST(NB-1)) u_load_cnt (
        .clk(clk), .rst(rst), .load(in_idle), .load_val('0),
        .en(state == S_LOAD), .count(load_addr), .tc(load_tc));

    ne_seq_counter #(.WIDTH(ADDRESSWIDTH), .LAST(ROWDEPTH-1)) u_row_cnt (
        .clk(clk), .rst(rst), .load(in_idle), .load_val('0),
        .en(state == S_DECODE), .count(row_addr), .tc(row_tc));

    ne_seq_counter #(.WIDTH(PIPECOUNTWIDTH), .LAST(PIPESTAGES-1)) u_drain_cnt (
        .clk(clk), .rst(rst), .load(in_idle), .load_val('0),
        .en(state == S_DRAIN), .count(drain_cnt), .tc(drain_tc));

    ne_seq_counter #(.WIDTH(ADDRESSWIDTH), .LAST(UNLOADCOUNT-1)) u_unload_cnt (
        .clk(clk), .rst(rst), .load(in_idle), .load_val('0),
        .en(unload_en), .count(unload_addr), .tc(unload_tc));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            pending        <= 1'b0;
            limit          <= '0;
            load_en        <= 1'b0;
            row_en         <= 1'b0;
            layer          <= '0;
            itr_count      <= '0;
            decoder_ready  <= 1'b0;
            busy           <= 1'b0;
            early_term     <= 1'b0;
            start_overflow <= 1'b0;
        end else begin
            decoder_ready <= 1'b0;
            // one start can queue behind the running frame; further ones are lost
            if (code_start && !in_idle) begin
                if (pending) start_overflow <= 1'b1;
                else         pending        <= 1'b1;
            end
            case (state)
                S_IDLE: if (code_start || pending) begin
                    state     <= S_LOAD;
                    pending   <= 1'b0;
                    limit     <= lim_eff;
                    itr_count <= '0;
                    load_en   <= 1'b1;
                    busy      <= 1'b1;
                end
                S_LOAD: if (load_tc) begin
                    state   <= S_DECODE;
                    load_en <= 1'b0;
                    row_en  <= 1'b1;
                    layer   <= '0;
                end
                S_DECODE: if (row_tc) begin
                    state  <= S_DRAIN;
                    row_en <= 1'b0;
                end
                S_DRAIN: if (drain_tc) begin
                    if (int'(layer) < LAYERS - 1) begin
                        state  <= S_DECODE;
                        layer  <= layer + 1'b1;
                        row_en <= 1'b1;
                    end else begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    itr_count  <= itr_next;
                    early_term <= syndrome_ok;
                    layer      <= '0;
                    if (syndrome_ok || itr_next == limit) begin
                        state         <= S_UNLOAD;
                        decoder_ready <= 1'b1;
                    end else begin
                        state  <= S_DECODE;
                        row_en <= 1'b1;
                    end
                end
                S_UNLOAD: if (unload_en && unload_tc) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ne_decode_sequencer.sv
// Directed bench for ne_decode_sequencer at default parameters.
module tb_ne_decode_sequencer;
    logic       clk = 1'b0, rst = 1'b0, code_start = 1'b0;
    logic       syndrome_ok = 1'b0, unload_ready = 1'b1;
    logic [3:0] iter_limit = 4'd2;
    logic       load_en, row_en, decoder_ready, unload_en, busy, early_term, start_overflow;
    logic [4:0] load_addr, row_addr, unload_addr;
    logic [0:0] layer;
    logic [3:0] itr_count;
    int         n_vec = 0, n_err = 0, n;

    ne_decode_sequencer dut (
        .clk(clk), .rst(rst), .code_start(code_start), .iter_limit(iter_limit),
        .syndrome_ok(syndrome_ok), .unload_ready(unload_ready),
        .load_en(load_en), .load_addr(load_addr), .row_en(row_en), .row_addr(row_addr),
        .layer(layer), .itr_count(itr_count), .decoder_ready(decoder_ready),
        .unload_en(unload_en), .unload_addr(unload_addr), .busy(busy),
        .early_term(early_term), .start_overflow(start_overflow));

    always #5 clk = ~clk;

    wire [26:0] all_out = {load_en, load_addr, row_en, row_addr, layer, itr_count,
                           decoder_ready, unload_en, unload_addr, busy, early_term,
                           start_overflow};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        code_start = 1'b1;
        tick();
        code_start = 1'b0;
    endtask

    task automatic do_load();
        for (int i = 0; i < 16; i++) begin
            chk("load_beat", {load_en, load_addr, busy}, {1'b1, 5'(i), 1'b1});
            tick();
        end
        chk("load_exit", {load_en, row_en, row_addr, layer, itr_count},
            {1'b0, 1'b1, 5'd0, 1'b0, 4'd0});
    endtask

    task automatic do_iter(input int k);
        for (int l = 0; l < 2; l++) begin
            for (int r = 0; r < 20; r++) begin
                chk("row", {row_en, layer, row_addr, itr_count}, {1'b1, 1'(l), 5'(r), 4'(k)});
                tick();
            end
            for (int d = 0; d < 15; d++) begin
                chk("drain", {row_en, row_addr, layer}, {1'b0, 5'd0, 1'(l)});
                tick();
            end
        end
        chk("check", {row_en, busy, decoder_ready, itr_count}, {1'b0, 1'b1, 1'b0, 4'(k)});
        tick();
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (decoder_ready !== 1'b1 && cnt < 400) begin
            tick();
            cnt++;
        end
    endtask

    task automatic do_unload(input logic [3:0] pat);
        int e, c;
        e = 0;
        c = 0;
        while (e < 17 && c < 100) begin
            unload_ready = pat[c % 4];
            #1;
            chk("unload", {decoder_ready, unload_en, unload_addr, busy},
                {(c == 0) ? 1'b1 : 1'b0, pat[c % 4], 5'(e), 1'b1});
            tick();
            if (pat[c % 4]) e++;
            c++;
        end
        unload_ready = 1'b1;
        #1;
        chk("unload_done", {busy, unload_en, unload_addr, decoder_ready}, 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_outputs", all_out, 32'd0);

        // start presented together with reset release
        rst = 1'b1;
        code_start = 1'b1;
        tick();
        code_start = 1'b0;

        // full two-iteration frame, cycle by cycle
        do_load();
        do_iter(0);
        do_iter(1);
        chk("s1_ready", {decoder_ready, itr_count, early_term, layer}, {1'b1, 4'd2, 1'b0, 1'b0});
        do_unload(4'b1111);
        chk("s1_final", {itr_count, early_term, start_overflow}, {4'd2, 1'b0, 1'b0});

        // early termination on first check
        syndrome_ok = 1'b1;
        pulse_start();
        do_load();
        wait_ready(n);
        chk("s2_latency", n, 71);
        chk("s2_state", {itr_count, early_term}, {4'd1, 1'b1});
        do_unload(4'b1111);
        syndrome_ok = 1'b0;

        // limit 0 and out-of-range limit both clamp to two iterations
        iter_limit = 4'd0;
        pulse_start();
        do_load();
        wait_ready(n);
        chk("s3_lim0_latency", n, 142);
        chk("s3_lim0_state", {itr_count, early_term}, {4'd2, 1'b0});
        do_unload(4'b1111);
        iter_limit = 4'd9;
        pulse_start();
        do_load();
        wait_ready(n);
        chk("s3_lim9_latency", n, 142);
        chk("s3_lim9_itr", itr_count, 4'd2);
        do_unload(4'b1111);

        // limit sampled at load entry; later change must not matter
        iter_limit = 4'd1;
        pulse_start();
        iter_limit = 4'd2;
        do_load();
        wait_ready(n);
        chk("s3_lim1_latency", n, 71);
        chk("s3_lim1_itr", itr_count, 4'd1);
        do_unload(4'b1111);

        // unload backpressure 1,0,0,1
        pulse_start();
        do_load();
        wait_ready(n);
        chk("s4_latency", n, 142);
        do_unload(4'b1001);

        // three starts during decode: one queued, overflow set
        pulse_start();
        do_load();
        for (int p = 0; p < 3; p++) begin
            pulse_start();
            tick();
        end
        chk("s5_overflow", start_overflow, 1'b1);
        wait_ready(n);
        chk("s5_latency", n, 136);
        do_unload(4'b1111);
        tick();
        chk("s5_requeue", {load_en, load_addr, busy}, {1'b1, 5'd0, 1'b1});
        do_load();
        wait_ready(n);
        chk("s5_q_latency", n, 142);
        do_unload(4'b1111);
        repeat (3) tick();
        chk("s5_single_queue", {busy, load_en, start_overflow}, {1'b0, 1'b0, 1'b1});

        // reset at layer 1 row 7, with a start pending
        pulse_start();
        do_load();
        pulse_start();
        n = 1;
        while (!(layer === 1'b1 && row_addr === 5'd7) && n < 200) begin
            tick();
            n++;
        end
        chk("s6_reach_row7", {n[7:0], row_en}, {8'd42, 1'b1});
        rst = 1'b0;
        #1;
        chk("s6_async_clear", all_out, 32'd0);
        tick();
        chk("s6_reset_edge", all_out, 32'd0);
        rst = 1'b1;
        repeat (3) tick();
        chk("s6_pending_cleared", {busy, load_en}, 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        code_start = 1'b1;
        tick();
        code_start = 1'b0;
        do_load();
        do_iter(0);
        do_iter(1);
        chk("s6_ready", {decoder_ready, itr_count}, {1'b1, 4'd2});
        do_unload(4'b1111);
        chk("s6_final", {itr_count, early_term, start_overflow}, {4'd2, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ne_decode_sequencer.md
NE_DECODE_SEQUENCER -- requirements
Module: ne_decode_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NB, 16, load beats per frame.
- ADDRESSWIDTH, 5, load/row/unload address width.
- ROWDEPTH, 20, row addresses per layer.
- LAYERS, 2, layers per iteration.
- LAYERBITS, 1, layer index width.
- MAXITRS, 2, hard iteration ceiling.
- ITRWIDTH, 4, iteration counter width.
- PIPESTAGES, 15, per-layer drain cycles.
- PIPECOUNTWIDTH, 4, drain counter width.
- UNLOADCOUNT, 17, unload beats per frame.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock; all logic on rising edge.
- rst, in, 1, asynchronous, active-low reset.
- code_start, in, 1, one-cycle pulse: input interface holds a complete frame.
- iter_limit, in, ITRWIDTH, runtime iteration limit.
- syndrome_ok, in, 1, parity satisfied; valid in CHECK.
- unload_ready, in, 1, output interface can accept a beat.
- load_en, out, 1, load strobe.
- load_addr, out, ADDRESSWIDTH, load address.
- row_en, out, 1, row-process strobe to the core.
- row_addr, out, ADDRESSWIDTH, row address.
- layer, out, LAYERBITS, current layer.
- itr_count, out, ITRWIDTH, completed iterations.
- decoder_ready, out, 1, one-cycle pulse at decode end.
- unload_en, out, 1, unload strobe.
- unload_addr, out, ADDRESSWIDTH, unload address.
- busy, out, 1, high in any state other than IDLE.
- early_term, out, 1, last frame stopped on syndrome_ok.
- start_overflow, out, 1, sticky: a start was dropped.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, DECODE, DRAIN, CHECK, UNLOAD.
REQ-004 IDLE -> LOAD on the cycle after code_start=1 or pending=1; pending clears on that entry.
REQ-005 LOAD: load_en=1 for exactly NB cycles, load_addr 0..NB-1, then -> DECODE with layer=0 and itr_count=0.
REQ-006 DECODE: row_en=1 for ROWDEPTH cycles, row_addr 0..ROWDEPTH-1, then -> DRAIN.
REQ-007 DRAIN: row_en=0 for PIPESTAGES cycles; then, if layer<LAYERS-1, layer+1 -> DECODE; else -> CHECK.
REQ-008 CHECK lasts one cycle and increments itr_count.
REQ-009 Effective limit: iter_limit, sampled at LOAD entry. If iter_limit is 0 or greater than MAXITRS, the limit SHALL be MAXITRS.
REQ-010 In CHECK, syndrome_ok=1 or incremented itr_count == limit -> decoder_ready pulse, -> UNLOAD. Otherwise layer=0 -> DECODE.
REQ-011 early_term SHALL be set to syndrome_ok at the CHECK exit and held until the next CHECK exit.
REQ-012 Iteration length SHALL be LAYERS*(ROWDEPTH+PIPESTAGES)+1 cycles (71 at defaults).
REQ-013 UNLOAD: unload_en = unload_ready (combinationally gated, registered address).
- unload_addr increments after every accepted beat.
- After beat UNLOADCOUNT-1 -> IDLE.
- unload_ready=0 stalls with address held and no timeout.
REQ-014 code_start while busy=1: sets pending if clear. If pending is already set, the start SHALL be dropped and start_overflow set.
REQ-015 code_start in IDLE with pending set SHALL be treated as one start and SHALL not set overflow.
REQ-016 All address and strobe outputs SHALL be 0 whenever their state is not active.
REQ-017 itr_count SHALL hold its final value through UNLOAD and IDLE until the next LOAD entry.

Reset
REQ-018 rst=0 SHALL immediately force IDLE and clear all counters, pending, early_term, start_overflow and every output to 0, including mid-LOAD, mid-DECODE and mid-UNLOAD.
REQ-019 The first code_start honoured after reset release SHALL be the one sampled on the first rising edge with rst=1.

Structure
REQ-020 The state encoding and the default parameter constants SHALL live in shared package ne_decoder_pkg.
REQ-021 One sub-module, ne_seq_counter, SHALL be used: a loadable up-counter with terminal-count flag, instanced for the load, row, drain and unload counters.
REQ-022 Outputs SHALL be registered, except unload_en per REQ-013.

Verification
REQ-023 Directed scenarios (defaults):
- Single frame, syndrome_ok=0, iter_limit=2: 16 load beats, then 2x71 decode cycles, decoder_ready once, 17 unload beats with addresses 0..16, early_term=0, itr_count=2.
- syndrome_ok=1 at the first CHECK with iter_limit=2: decoder_ready 71 cycles after LOAD exit, itr_count=1, early_term=1.
- iter_limit=0 and then iter_limit=9: both run exactly MAXITRS=2 iterations.
- unload_ready toggling 1,0,0,1 during UNLOAD: exactly 17 beats, addresses contiguous, no skips or repeats.
- Three code_start pulses during DECODE: one frame queued (next LOAD follows IDLE), start_overflow=1.
- rst=0 at row_addr=7 of layer 1: all outputs 0 next edge; after release, a new code_start runs a full clean frame.
